// File: rtl/reg_wb_arbiter.sv
// reg_wb_arbiter
// Write-back arbiter plus pending-register scoreboard for a small in-order core.
// Three producers (ALU, load unit, mul/div) compete for the single register-file
// write port. A round-robin pointer picks one valid requester per cycle. The
// accepted write appears on the registered register-file port one cycle later.
// A 32-entry busy vector tracks destinations that issue has marked pending. An
// entry is cleared on the edge where the register file captures the write.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   req_valid[2:0]           per-requester write request (0 ALU, 1 load, 2 mul/div)
//   req_ready[2:0]           per-requester accept, one-hot or zero (combinational)
//   req_rd_add[3*ADDR_W-1:0] destination per requester, requester i at [ADDR_W*i +: ADDR_W]
//   req_w_data[3*DATA_W-1:0] write data per requester, requester i at [DATA_W*i +: DATA_W]
//   w_en, rd_add, w_data     registered register-file write port
//   grant_id[1:0]            requester that produced the current write
//   sb_set_en, sb_set_add    mark a destination register pending
//   rs1_add, rs2_add         source lookup addresses
//   rs1_busy, rs2_busy       pending flags for the sources (combinational)
module reg_wb_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [2:0]            req_valid,
    output logic [2:0]            req_ready,
    input  logic [3*ADDR_W-1:0]   req_rd_add,
    input  logic [3*DATA_W-1:0]   req_w_data,
    output logic                  w_en,
    output logic [ADDR_W-1:0]     rd_add,
    output logic [DATA_W-1:0]     w_data,
    output logic [1:0]            grant_id,
    input  logic                  sb_set_en,
    input  logic [ADDR_W-1:0]     sb_set_add,
    input  logic [ADDR_W-1:0]     rs1_add,
    input  logic [ADDR_W-1:0]     rs2_add,
    output logic                  rs1_busy,
    output logic                  rs2_busy
);

    localparam int NREQ = 3;
    localparam int NREG = 1 << ADDR_W;

    // Wrap-around index: (start + off) mod 3, for start and off in 0..2.
    function automatic logic [1:0] f_wrap(input logic [1:0] start, input logic [1:0] off);
        logic [2:0] sum;
        sum = {1'b0, start} + {1'b0, off};
        if (sum >= 3'd3) begin
            sum = sum - 3'd3;
        end
        return sum[1:0];
    endfunction

    logic [1:0]        r_last_grant;
    logic              r_w_en;
    logic [ADDR_W-1:0] r_rd_add;
    logic [DATA_W-1:0] r_w_data;
    logic [1:0]        r_grant_id;
    logic [NREG-1:0]   r_busy;

    logic [ADDR_W-1:0] w_rd_arr   [NREQ];
    logic [DATA_W-1:0] w_data_arr [NREQ];
    logic [1:0]        w_start;
    logic [2:0]        w_grant_oh;
    logic [1:0]        w_grant_id;
    logic              w_xfer;
    logic [ADDR_W-1:0] w_sel_rd;
    logic [DATA_W-1:0] w_sel_data;
    logic              w_sel_nonzero;
    logic [NREG-1:0]   w_set_hit;
    logic [NREG-1:0]   w_clr_hit;

    genvar gi;

    // Unpack the flat requester buses.
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign w_rd_arr[gi]   = req_rd_add[gi*ADDR_W +: ADDR_W];
            assign w_data_arr[gi] = req_w_data[gi*DATA_W +: DATA_W];
        end
    endgenerate

    // Search starts one past the last winner.
    assign w_start = f_wrap(r_last_grant, 2'd1);

    always_comb begin
        w_grant_oh = 3'b000;
        w_grant_id = 2'd0;
        w_xfer     = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (!w_xfer && req_valid[f_wrap(w_start, 2'(k))]) begin
                w_xfer     = 1'b1;
                w_grant_id = f_wrap(w_start, 2'(k));
                w_grant_oh[f_wrap(w_start, 2'(k))] = 1'b1;
            end
        end
        // Nothing is accepted while reset is held.
        if (rst) begin
            w_grant_oh = 3'b000;
            w_xfer     = 1'b0;
        end
    end

    assign req_ready     = w_grant_oh;
    assign w_sel_rd      = w_rd_arr[w_grant_id];
    assign w_sel_data    = w_data_arr[w_grant_id];
    assign w_sel_nonzero = (w_sel_rd != '0);

    // A write to x0 is consumed (handshake and pointer move) but never reaches
    // the port, so the port contents keep showing the last real write.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_grant <= 2'd2;
            r_w_en       <= 1'b0;
            r_rd_add     <= '0;
            r_w_data     <= '0;
            r_grant_id   <= 2'd0;
        end else begin
            r_w_en <= w_xfer && w_sel_nonzero;
            if (w_xfer) begin
                r_last_grant <= w_grant_id;
                if (w_sel_nonzero) begin
                    r_rd_add   <= w_sel_rd;
                    r_w_data   <= w_sel_data;
                    r_grant_id <= w_grant_id;
                end
            end
        end
    end

    assign w_en     = r_w_en;
    assign rd_add   = r_rd_add;
    assign w_data   = r_w_data;
    assign grant_id = r_grant_id;

    // Per-register set/clear decode. Entry 0 never sets, so it stays 0.
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_sb
            if (gi == 0) begin : g_zero
                assign w_set_hit[gi] = 1'b0;
                assign w_clr_hit[gi] = 1'b0;
            end else begin : g_reg
                assign w_set_hit[gi] = sb_set_en && (sb_set_add == ADDR_W'(gi));
                assign w_clr_hit[gi] = r_w_en && (r_rd_add == ADDR_W'(gi));
            end
        end
    endgenerate

    // Clear first, then set, so a same-edge set of the register being written
    // back leaves it pending (a newer producer has claimed it).
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= '0;
        end else begin
            r_busy <= (r_busy & ~w_clr_hit) | w_set_hit;
        end
    end

    assign rs1_busy = (rs1_add != '0) && r_busy[rs1_add];
    assign rs2_busy = (rs2_add != '0) && r_busy[rs2_add];

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Directed bench for reg_wb_arbiter. The driver applies vectors on the falling
// edge and queues every register-file write it expects. A monitor pops and
// compares on each rising edge where a write is due or w_en is seen.
module tb_reg_wb_arbiter;

    logic        clk;
    logic        rst;
    logic [2:0]  req_valid;
    logic [2:0]  req_ready;
    logic [14:0] req_rd_add;
    logic [95:0] req_w_data;
    logic        w_en;
    logic [4:0]  rd_add;
    logic [31:0] w_data;
    logic [1:0]  grant_id;
    logic        sb_set_en;
    logic [4:0]  sb_set_add;
    logic [4:0]  rs1_add;
    logic [4:0]  rs2_add;
    logic        rs1_busy;
    logic        rs2_busy;

    reg_wb_arbiter #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_rd_add (req_rd_add),
        .req_w_data (req_w_data),
        .w_en       (w_en),
        .rd_add     (rd_add),
        .w_data     (w_data),
        .grant_id   (grant_id),
        .sb_set_en  (sb_set_en),
        .sb_set_add (sb_set_add),
        .rs1_add    (rs1_add),
        .rs2_add    (rs2_add),
        .rs1_busy   (rs1_busy),
        .rs2_busy   (rs2_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int          due;
        logic [4:0]  rd;
        logic [31:0] data;
        logic [1:0]  id;
    } exp_t;

    exp_t q[$];
    int   cyc   = 0;
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("ok   %s = %h", name, act);
        end
    endtask

    // Drive one cycle of stimulus, check the handshake, queue the expected write.
    task automatic apply(input logic [2:0] v, input logic [14:0] rds, input logic [95:0] ds,
                         input logic [2:0] exp_rdy, input logic sb_en, input logic [4:0] sb_a);
        req_valid  = v;
        req_rd_add = rds;
        req_w_data = ds;
        sb_set_en  = sb_en;
        sb_set_add = sb_a;
        #1;
        chk("req_ready", {29'd0, req_ready}, {29'd0, exp_rdy});
        for (int i = 0; i < 3; i++) begin
            if (exp_rdy[i] && (rds[i*5 +: 5] != 5'd0)) begin
                q.push_back('{due: cyc + 1, rd: rds[i*5 +: 5], data: ds[i*32 +: 32], id: 2'(i)});
            end
        end
        @(negedge clk);
    endtask

    // Monitor: compares the register-file port against the queue head.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (q.size() > 0 && q[0].due == cyc) begin
                e = q.pop_front();
                n_vec++;
                if (w_en !== 1'b1 || rd_add !== e.rd || w_data !== e.data || grant_id !== e.id) begin
                    n_err++;
                    $display("FAIL write@%0d: got w_en=%b rd=%0d data=%h id=%0d expected w_en=1 rd=%0d data=%h id=%0d",
                             cyc, w_en, rd_add, w_data, grant_id, e.rd, e.data, e.id);
                end else begin
                    $display("write@%0d rd=%0d data=%h id=%0d", cyc, rd_add, w_data, grant_id);
                end
            end else if (w_en === 1'b1) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected write@%0d: got w_en=1 rd=%0d data=%h expected w_en=0",
                         cyc, rd_add, w_data);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    localparam logic [95:0] D_ABC = {32'hCCCC_0003, 32'hBBBB_0002, 32'hAAAA_0001};

    initial begin
        rst = 1'b1;
        req_valid = 3'b000; req_rd_add = '0; req_w_data = '0;
        sb_set_en = 1'b0; sb_set_add = '0; rs1_add = 5'd4; rs2_add = 5'd0;
        @(negedge clk);

        // Reset: no accepts, scoreboard ignores sets.
        apply(3'b111, {5'd3, 5'd2, 5'd1}, D_ABC, 3'b000, 1'b1, 5'd4);
        apply(3'b111, {5'd3, 5'd2, 5'd1}, D_ABC, 3'b000, 1'b1, 5'd4);
        rst = 1'b0;
        chk("rst w_en", {31'd0, w_en}, 32'd0);
        chk("rst rd_add", {27'd0, rd_add}, 32'd0);
        chk("rst w_data", w_data, 32'd0);
        chk("rst grant_id", {30'd0, grant_id}, 32'd0);
        chk("rst busy4", {31'd0, rs1_busy}, 32'd0);

        // All three valid: grants 0,1,2.
        apply(3'b111, {5'd3, 5'd2, 5'd1}, D_ABC, 3'b001, 1'b0, 5'd0);
        apply(3'b111, {5'd3, 5'd2, 5'd1}, D_ABC, 3'b010, 1'b0, 5'd0);
        apply(3'b111, {5'd3, 5'd2, 5'd1}, D_ABC, 3'b100, 1'b0, 5'd0);

        // Single ALU write, then idle: port holds its values with w_en low.
        apply(3'b001, {5'd0, 5'd0, 5'd5}, {64'd0, 32'hDEAD_BEEF}, 3'b001, 1'b0, 5'd0);
        apply(3'b000, 15'd0, 96'd0, 3'b000, 1'b0, 5'd0);
        chk("hold w_en", {31'd0, w_en}, 32'd0);
        chk("hold rd_add", {27'd0, rd_add}, 32'd5);
        chk("hold w_data", w_data, 32'hDEAD_BEEF);
        chk("hold grant_id", {30'd0, grant_id}, 32'd0);

        // Load to x0: accepted, no write, pointer moves to 1 so requester 2 is next.
        apply(3'b010, 15'd0, {32'd0, 32'h0000_1234, 32'd0}, 3'b010, 1'b0, 5'd0);
        apply(3'b111, {5'd6, 5'd11, 5'd12}, {32'h6666_6666, 32'h1111_1111, 32'h1212_1212}, 3'b100, 1'b0, 5'd0);

        // Scoreboard set / clear on r7.
        rs1_add = 5'd7;
        sb_set_en = 1'b1; sb_set_add = 5'd7;
        #1;
        chk("no bypass set", {31'd0, rs1_busy}, 32'd0);
        apply(3'b000, 15'd0, 96'd0, 3'b000, 1'b1, 5'd7);
        chk("busy7 set", {31'd0, rs1_busy}, 32'd1);
        apply(3'b100, {5'd7, 5'd0, 5'd0}, {32'h0000_00D7, 64'd0}, 3'b100, 1'b0, 5'd0);
        chk("busy7 during w_en", {31'd0, rs1_busy}, 32'd1);
        apply(3'b000, 15'd0, 96'd0, 3'b000, 1'b0, 5'd0);
        chk("busy7 cleared", {31'd0, rs1_busy}, 32'd0);
        apply(3'b000, 15'd0, 96'd0, 3'b000, 1'b1, 5'd7);
        apply(3'b100, {5'd7, 5'd0, 5'd0}, {32'h0000_00E7, 64'd0}, 3'b100, 1'b0, 5'd0);
        apply(3'b000, 15'd0, 96'd0, 3'b000, 1'b1, 5'd7);
        chk("busy7 set wins", {31'd0, rs1_busy}, 32'd1);

        // Set of x0 is ignored.
        rs1_add = 5'd0; rs2_add = 5'd0;
        apply(3'b000, 15'd0, 96'd0, 3'b000, 1'b1, 5'd0);
        chk("x0 rs1", {31'd0, rs1_busy}, 32'd0);
        chk("x0 rs2", {31'd0, rs2_busy}, 32'd0);

        // Mid-operation reset.
        rs1_add = 5'd3; rs2_add = 5'd9;
        apply(3'b000, 15'd0, 96'd0, 3'b000, 1'b1, 5'd3);
        apply(3'b000, 15'd0, 96'd0, 3'b000, 1'b1, 5'd9);
        chk("busy3 set", {31'd0, rs1_busy}, 32'd1);
        chk("busy9 set", {31'd0, rs2_busy}, 32'd1);
        apply(3'b001, 15'd0, 96'd0, 3'b001, 1'b0, 5'd0);
        rst = 1'b1;
        apply(3'b111, {5'd3, 5'd2, 5'd1}, D_ABC, 3'b000, 1'b0, 5'd0);
        rst = 1'b0;
        chk("post-rst w_en", {31'd0, w_en}, 32'd0);
        chk("post-rst busy3", {31'd0, rs1_busy}, 32'd0);
        chk("post-rst busy9", {31'd0, rs2_busy}, 32'd0);
        apply(3'b111, {5'd3, 5'd2, 5'd1}, D_ABC, 3'b001, 1'b0, 5'd0);
        apply(3'b111, {5'd3, 5'd2, 5'd1}, D_ABC, 3'b010, 1'b0, 5'd0);
        apply(3'b111, {5'd3, 5'd2, 5'd1}, D_ABC, 3'b100, 1'b0, 5'd0);

        apply(3'b000, 15'd0, 96'd0, 3'b000, 1'b0, 5'd0);
        apply(3'b000, 15'd0, 96'd0, 3'b000, 1'b0, 5'd0);
        chk("queue drained", q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/reg_wb_arbiter.md
REG_WB_ARBITER -- requirements
Module: reg_wb_arbiter

Interface
REQ-001 Parameter: DATA_W, 32, write-data width.
REQ-002 Parameter: ADDR_W, 5, register address width (32 registers).
REQ-003 clk  in  1  single clock; all state updates on posedge.
REQ-004 rst  in  1  reset; synchronous, active-high.
REQ-005 req_valid  in  3  per-requester write request (bit 0 ALU, bit 1 load unit, bit 2 mul/div).
REQ-006 req_ready  out  3  per-requester accept, one-hot or zero.
REQ-007 req_rd_add  in  3*ADDR_W  destination per requester; requester i at bits [5i+4:5i].
REQ-008 req_w_data  in  3*DATA_W  write data per requester; requester i at bits [32i+31:32i].
REQ-009 w_en  out  1  register-file write enable, registered.
REQ-010 rd_add  out  ADDR_W  register-file write address, registered.
REQ-011 w_data  out  DATA_W  register-file write data, registered.
REQ-012 grant_id  out  2  index of the requester driving the current w_en; registered.
REQ-013 sb_set_en  in  1  issue stage marks a destination pending.
REQ-014 sb_set_add  in  ADDR_W  register marked pending.
REQ-015 rs1_add, rs2_add  in  ADDR_W each  source lookup addresses.
REQ-016 rs1_busy, rs2_busy  out  1 each  combinational pending flag for the source.

Function
REQ-017 Arbitration SHALL be round-robin over valid requesters, starting at (last_grant+1) mod 3 and searching upward with wrap.
REQ-018 At most one request SHALL be accepted per cycle; req_ready[i] SHALL be 1 only for the granted i, combinational on req_valid and the pointer.
REQ-019 A transfer occurs when req_valid[i] & req_ready[i]; requester holds valid, rd_add and data stable until then.
REQ-020 On a transfer, last_grant SHALL update to i; with no transfer it SHALL hold.
REQ-021 A transfer in cycle N SHALL produce w_en=1, rd_add, w_data and grant_id in cycle N+1 (latency 1); with no transfer in cycle N, w_en=0 in cycle N+1.
REQ-022 A transfer with rd_add=0 SHALL be accepted (ready=1, pointer updates), but w_en SHALL stay 0 in N+1.
REQ-023 rd_add, w_data and grant_id SHALL hold their last values while w_en=0.
REQ-024 Scoreboard: a 32-bit busy vector; sb_set_en=1 SHALL set busy[sb_set_add] at the clock edge; writes to address 0 SHALL be ignored.
REQ-025 When w_en=1, busy[rd_add] SHALL clear at that clock edge, the edge on which the register file captures the write.
REQ-026 Same-edge set and clear of the same register SHALL leave busy=1, with set winning.
REQ-027 rs1_busy = busy[rs1_add] and rs2_busy = busy[rs2_add]; address 0 SHALL always read 0; no bypass of same-cycle set or clear.
REQ-028 busy[0] SHALL always be 0.

Reset
REQ-029 While rst=1: req_ready=0, no transfer, scoreboard ignores sb_set_en.
REQ-030 After the rst edge: w_en=0, rd_add=0, w_data=0, grant_id=0, busy=all 0, and last_grant=2 so that first-cycle priority is 0,1,2.
REQ-031 rst asserted mid-operation SHALL drop any pending output write and clear the whole scoreboard at that edge, with no partial writes.

Verification
REQ-032 Reset, then req_valid=3'b111 held for 3 cycles -> grants 0,1,2 on consecutive cycles; w_en=1 with grant_id 0,1,2 one cycle later each.
REQ-033 ALU request rd_add=5, data 0xDEADBEEF in cycle N -> cycle N+1 w_en=1, rd_add=5, w_data=0xDEADBEEF; cycle N+2 w_en=0.
REQ-034 Load request rd_add=0, data 0x1234 -> req_ready[1]=1, pointer moves to 1, w_en stays 0, busy unchanged.
REQ-035 sb_set_en with add 7, then rs1_add=7 -> rs1_busy=1; mul/div writes rd 7 -> rs1_busy=0 after the w_en edge; with sb_set_en add 7 on that same edge -> rs1_busy stays 1.
REQ-036 sb_set_en with add 0 -> rs1_add=0 and rs2_add=0 read busy 0.
REQ-037 Requests outstanding and busy bits 3,9 set, then rst pulsed one cycle -> next cycle w_en=0, all busy=0, next grant order 0,1,2.
